// File: rtl/memory_unit_if.sv
// Bus bundle for the data memory: write enable, shared address, write data, read data.
// Ports: master drives we/address/write_data and samples read_data; slave is the memory.
interface memory_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output we,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  we,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/memory_unit.sv
// Single-port 2**ADDR_WIDTH x DATA_WIDTH data memory, synchronous write, shared address.
// Ports: clk, rst_n (sync, active-low, clears every word), bus (memory_unit_if.slave).
// Option MEMORY_UNIT_REG_READ_EN: registered read-first read_data, one-cycle latency;
// otherwise read_data is a combinational, zero-latency view of mem[address].
module memory_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    memory_unit_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Built from flops rather than a RAM macro: reset must clear every word.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.we) begin
            mem_q[bus.address] <= bus.write_data;
        end
    end

`ifdef MEMORY_UNIT_REG_READ_EN
    logic [DATA_WIDTH-1:0] rdata_q;

    // Samples the pre-edge array contents, so a same-address write yields the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[bus.address];
        end
    end

    assign bus.read_data = rdata_q;
`else
    assign bus.read_data = mem_q[bus.address];
`endif
endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit (combinational or registered read build).
// Ports: none; drives the DUT through a memory_unit_if instance.
module tb_memory_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    memory_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    memory_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus.we         = 1'b1;
        bus.address    = a;
        bus.write_data = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        bus.we      = 1'b0;
        bus.address = a;
`ifdef MEMORY_UNIT_REG_READ_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        d = bus.read_data;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [7:0]  addrs [3];
        addrs[0] = 8'h00;
        addrs[1] = 8'h7F;
        addrs[2] = 8'hFF;
        rst_n = 1'b0;
        bus.we = 1'b0;
        bus.address = 8'h00;
        bus.write_data = 16'h0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i], d);
            checks++;
            if (d !== 16'h0000) begin
                $display("FAIL reset addr=%h got=%h exp=%h", addrs[i], d, 16'h0000);
                errors++;
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] d;
        wr(8'hA0, 16'h1234);
        rd(8'hA0, d);
        checks++;
        if (d !== 16'h1234) begin
            $display("FAIL write_read got=%h exp=%h", d, 16'h1234);
            errors++;
        end
    endtask

    task automatic test_rdw();
        bus.we         = 1'b1;
        bus.address    = 8'h30;
        bus.write_data = 16'hABCD;
`ifdef MEMORY_UNIT_REG_READ_EN
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        checks++;
        if (bus.read_data !== 16'h0000) begin
            $display("FAIL rdw_old got=%h exp=%h", bus.read_data, 16'h0000);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.read_data !== 16'hABCD) begin
            $display("FAIL rdw_new got=%h exp=%h", bus.read_data, 16'hABCD);
            errors++;
        end
`else
        #1;
        checks++;
        if (bus.read_data !== 16'h0000) begin
            $display("FAIL rdw_old got=%h exp=%h", bus.read_data, 16'h0000);
            errors++;
        end
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        checks++;
        if (bus.read_data !== 16'hABCD) begin
            $display("FAIL rdw_new got=%h exp=%h", bus.read_data, 16'hABCD);
            errors++;
        end
`endif
    endtask

    task automatic test_boundaries();
        logic [15:0] d;
        wr(8'h00, 16'hBEEF);
        wr(8'hFF, 16'hCAFE);
        rd(8'h00, d);
        checks++;
        if (d !== 16'hBEEF) begin
            $display("FAIL bound_lo got=%h exp=%h", d, 16'hBEEF);
            errors++;
        end
        rd(8'hFF, d);
        checks++;
        if (d !== 16'hCAFE) begin
            $display("FAIL bound_hi got=%h exp=%h", d, 16'hCAFE);
            errors++;
        end
        rd(8'h01, d);
        checks++;
        if (d !== 16'h0000) begin
            $display("FAIL bound_01 got=%h exp=%h", d, 16'h0000);
            errors++;
        end
    endtask

    task automatic test_overwrite();
        logic [15:0] d;
        wr(8'h0F, 16'h0F0F);
        wr(8'h11, 16'h1F1F);
        wr(8'h10, 16'h1111);
        wr(8'h10, 16'h2222);
        rd(8'h10, d);
        checks++;
        if (d !== 16'h2222) begin
            $display("FAIL overwrite got=%h exp=%h", d, 16'h2222);
            errors++;
        end
        rd(8'h0F, d);
        checks++;
        if (d !== 16'h0F0F) begin
            $display("FAIL nbr_0f got=%h exp=%h", d, 16'h0F0F);
            errors++;
        end
        rd(8'h11, d);
        checks++;
        if (d !== 16'h1F1F) begin
            $display("FAIL nbr_11 got=%h exp=%h", d, 16'h1F1F);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] exp;
        bus.we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.address    = 8'h40 + 8'(i);
            bus.write_data = 16'h5A00 + 16'(i * 3);
            @(posedge clk);
            #1;
        end
        bus.we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = 16'h5A00 + 16'(i * 3);
            rd(8'h40 + 8'(i), d);
            checks++;
            if (d !== exp) begin
                $display("FAIL b2b addr=%h got=%h exp=%h", 8'h40 + 8'(i), d, exp);
                errors++;
            end
        end
    endtask

    task automatic test_we_guard();
        logic [15:0] d;
        bus.we         = 1'b0;
        bus.address    = 8'h20;
        bus.write_data = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        rd(8'h20, d);
        checks++;
        if (d !== 16'h0000) begin
            $display("FAIL we_guard got=%h exp=%h", d, 16'h0000);
            errors++;
        end
    endtask

    task automatic test_reset_priority();
        logic [15:0] d;
        rst_n          = 1'b0;
        bus.we         = 1'b1;
        bus.address    = 8'hA0;
        bus.write_data = 16'h5555;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bus.we = 1'b0;
        checks++;
        if (bus.read_data !== 16'h0000) begin
            $display("FAIL rst_out got=%h exp=%h", bus.read_data, 16'h0000);
            errors++;
        end
        rd(8'hA0, d);
        checks++;
        if (d !== 16'h0000) begin
            $display("FAIL rst_prio got=%h exp=%h", d, 16'h0000);
            errors++;
        end
        rd(8'h00, d);
        checks++;
        if (d !== 16'h0000) begin
            $display("FAIL rst_clear got=%h exp=%h", d, 16'h0000);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_rdw();
        test_boundaries();
        test_overwrite();
        test_back_to_back();
        test_we_guard();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
